step_pulse_generator: RTL and testbench
=======================================

Name: step_pulse_generator

Overview:
- Initiator side of the digit-counter increase/decrease interface.
- Conditions two raw push-buttons (up, down): synchronise, debounce, then emit single-cycle increase/decrease step pulses.
- Emits one pulse on press, then auto-repeat pulses while the button is held.
- Sits between board buttons and a counter chain; guarantees increase and decrease are never high in the same cycle.

Parameters:
- CNT_W, 16, width of internal debounce/hold/repeat counters.
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised input must differ from its debounced level before that level flips (≥1).
- HOLD_CYCLES, 1000, cycles from first pulse to first repeat pulse (≥2).
- REPEAT_CYCLES, 200, cycles between repeat pulses (≥2).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous active-low reset.
- btn_up  input  1  raw asynchronous up button, active-high.
- btn_down  input  1  raw asynchronous down button, active-high.
- enable  input  1  synchronous; low suppresses all pulses.
- increase  output  1  registered single-cycle up step.
- decrease  output  1  registered single-cycle down step.
- repeating  output  1  high while the FSM is in REPEAT.

Behaviour:
- Reset: all outputs 0. Sync flops, debounced levels and counters 0. FSM = IDLE.
- Reset is async-asserted and honoured mid-operation; no pulse is emitted on the first cycle after deassertion.
- Synchroniser: two flops per button.
- Debounce, per button:
  - Counter increments while sync output differs from the debounced level; it clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never flip the level.
- Latency: raw held high from edge k → increase high in the cycle after edge k+DEBOUNCE_CYCLES+3, for exactly one cycle.
- FSM states: IDLE, HOLD_WAIT, REPEAT, RELEASE_WAIT. Owner register dir: 0 = up, 1 = down.
- IDLE:
  - On a deb_up rise with enable=1: dir=0, pulse increase, go to HOLD_WAIT, clear timer.
  - Else on a deb_down rise with enable=1: dir=1, pulse decrease, go to HOLD_WAIT.
  - Simultaneous rises: up wins, matching counter precedence.
  - If both buttons are already debounced-high on entry to IDLE, no pulse; go to RELEASE_WAIT.
- HOLD_WAIT:
  - Timer increments each cycle.
  - When the timer reaches HOLD_CYCLES-1: pulse the owner direction, clear timer, go to REPEAT.
  - If the owner debounced level falls first: go to IDLE with no pulse.
- REPEAT:
  - A pulse fires every REPEAT_CYCLES cycles.
  - If the owner is released: go to IDLE.
- Non-owner button pressed during HOLD_WAIT/REPEAT: ignored. On owner release, if the non-owner is still high, go to RELEASE_WAIT instead of IDLE.
- RELEASE_WAIT: stay until both debounced levels are 0, then go to IDLE. No pulses.
- enable=0 in any state:
  - Outputs forced 0.
  - If any debounced level is high, go to RELEASE_WAIT; else go to IDLE.
  - Re-enabling while held requires release and re-press.
- Mutual exclusion: increase & decrease = 0 in every cycle (invariant).
- Timer saturates; there is no wrap. HOLD_CYCLES and REPEAT_CYCLES must be < 2^CNT_W.

Optional Feature:
- STEP_AUTO_REPEAT_EN defined: behaviour as above.
- Not defined:
  - HOLD_WAIT and REPEAT logic and the timer are compiled out.
  - After the press pulse, the FSM goes directly to RELEASE_WAIT.
  - repeating is tied to 0.
  - Exactly one pulse per press.

Test Plan:
- DEBOUNCE_CYCLES=4. Raise btn_up at edge 10 and hold 20 cycles, release → increase high only in the cycle after edge 17, decrease never high; no repeat (HOLD_CYCLES=1000).
- DEBOUNCE_CYCLES=4. btn_down glitches high for 3 cycles, repeated 5 times → no decrease pulse; debounced level stays 0.
- DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5. Hold btn_up 40 cycles:
  - first increase pulse, second 10 cycles later, then every 5 cycles;
  - repeating=1 from the second pulse until release;
  - pulse count matches the formula.
  - Repeat with STEP_AUTO_REPEAT_EN undefined → exactly 1 pulse.
- Raise btn_up and btn_down on the same edge → one increase pulse, zero decrease. Release up while down is held → no decrease until down is released and re-pressed.
- Hold btn_down in REPEAT and drop enable for 1 cycle → no further pulses while held; repeating=0. Release then re-press → single decrease after debounce latency.
- Assert rst low mid-REPEAT for 2 cycles → outputs 0 immediately (async); the held button produces no pulse until released and re-pressed.

Source files
------------

// File: rtl/step_pulse_generator.sv
// step_pulse_generator
//   Initiator side of the digit-counter increase/decrease interface. Two raw
//   push-buttons are synchronised, debounced and turned into single-cycle
//   step pulses: one on press, then (optionally) auto-repeat while held.
//   increase and decrease are never high in the same cycle.
//
//   Optional feature macro: STEP_AUTO_REPEAT_EN
//     defined   : hold/repeat timing (HOLD_WAIT, REPEAT states, timer)
//     undefined : exactly one pulse per press, repeating tied low
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-low reset
//   btn_up     in   raw asynchronous up button, active-high
//   btn_down   in   raw asynchronous down button, active-high
//   enable     in   synchronous; low suppresses all pulses
//   increase   out  registered single-cycle up step
//   decrease   out  registered single-cycle down step
//   repeating  out  high while the FSM is in REPEAT
module step_pulse_generator #(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic enable,
  output logic increase,
  output logic decrease,
  output logic repeating
);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;
`ifdef STEP_AUTO_REPEAT_EN
  localparam logic [1:0] ST_HOLD_WAIT    = 2'd1;
  localparam logic [1:0] ST_REPEAT       = 2'd2;
  localparam logic [1:0] ST_AFTER_PRESS  = ST_HOLD_WAIT;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`else
  localparam logic [1:0] ST_AFTER_PRESS  = ST_RELEASE_WAIT;
`endif
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) sat_inc = v;
    else                    sat_inc = v + CNT_W'(1);
  endfunction

  // bit 0 = up button, bit 1 = down button throughout
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            deb_q, deb_d, deb_prev_q;
  logic [1:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]            startup_q, startup_d;
  logic [1:0]            block_q, block_d;
  logic [1:0]            rise_s;
  logic [1:0]            state_q, state_d;
  logic                  inc_d, dec_d;
  logic                  increase_q, decrease_q, repeating_q;
`ifdef STEP_AUTO_REPEAT_EN
  logic                  dir_q, dir_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic                  owner_s, other_s;
`endif

  // Debounce: the level flips one cycle after the mismatch count reaches
  // DEBOUNCE_CYCLES; any agreement before that clears the count.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (deb_cnt_q[i] == DEB_LAST) begin
        deb_d[i]     = ~deb_q[i];
        deb_cnt_d[i] = '0;
      end else if (sync2_q[i] != deb_q[i]) begin
        deb_cnt_d[i] = sat_inc(deb_cnt_q[i]);
      end else begin
        deb_cnt_d[i] = '0;
      end
    end
  end

  // Buttons already held while reset is released must not produce a press:
  // during the first two cycles (synchroniser still filling) any high sample
  // blocks that button until it is seen released.
  always_comb begin
    startup_d = (startup_q == 2'd2) ? startup_q : startup_q + 2'd1;
    block_d   = block_q;
    for (int i = 0; i < 2; i++) begin
      if (startup_q != 2'd2) begin
        block_d[i] = block_q[i] | sync1_q[i];
      end else if (!sync2_q[i] && !deb_q[i]) begin
        block_d[i] = 1'b0;
      end else begin
        block_d[i] = block_q[i];
      end
    end
  end

  // Press detection on the debounced levels
  always_comb begin
    rise_s = deb_q & ~deb_prev_q & ~block_q;
  end

`ifdef STEP_AUTO_REPEAT_EN
  // Owner / non-owner debounced levels for the hold and repeat states
  always_comb begin
    owner_s = dir_q ? deb_q[1] : deb_q[0];
    other_s = dir_q ? deb_q[0] : deb_q[1];
  end
`endif

  // Step FSM next-state and pulse decode
  always_comb begin
    state_d = state_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
`ifdef STEP_AUTO_REPEAT_EN
    dir_d   = dir_q;
    timer_d = timer_q;
`endif
    if (!enable) begin
      state_d = (|deb_q) ? ST_RELEASE_WAIT : ST_IDLE;
`ifdef STEP_AUTO_REPEAT_EN
      timer_d = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // up is checked first so a simultaneous press resolves to up
          if (rise_s[0]) begin
            inc_d   = 1'b1;
            state_d = ST_AFTER_PRESS;
`ifdef STEP_AUTO_REPEAT_EN
            dir_d   = 1'b0;
            timer_d = '0;
`endif
          end else if (rise_s[1]) begin
            dec_d   = 1'b1;
            state_d = ST_AFTER_PRESS;
`ifdef STEP_AUTO_REPEAT_EN
            dir_d   = 1'b1;
            timer_d = '0;
`endif
          end else if (&deb_q) begin
            state_d = ST_RELEASE_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
`ifdef STEP_AUTO_REPEAT_EN
        ST_HOLD_WAIT: begin
          // release takes priority over a pulse due in the same cycle
          if (!owner_s) begin
            state_d = other_s ? ST_RELEASE_WAIT : ST_IDLE;
          end else if (timer_q == HOLD_LAST) begin
            inc_d   = ~dir_q;
            dec_d   = dir_q;
            timer_d = '0;
            state_d = ST_REPEAT;
          end else begin
            timer_d = sat_inc(timer_q);
          end
        end
        ST_REPEAT: begin
          if (!owner_s) begin
            state_d = other_s ? ST_RELEASE_WAIT : ST_IDLE;
          end else if (timer_q == REP_LAST) begin
            inc_d   = ~dir_q;
            dec_d   = dir_q;
            timer_d = '0;
          end else begin
            timer_d = sat_inc(timer_q);
          end
        end
`endif
        ST_RELEASE_WAIT: begin
          if (deb_q == 2'b00) state_d = ST_IDLE;
          else                state_d = ST_RELEASE_WAIT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // All sequential state, including the registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      deb_q       <= 2'b00;
      deb_prev_q  <= 2'b00;
      deb_cnt_q   <= '0;
      startup_q   <= 2'd0;
      block_q     <= 2'b00;
      state_q     <= ST_IDLE;
      increase_q  <= 1'b0;
      decrease_q  <= 1'b0;
      repeating_q <= 1'b0;
`ifdef STEP_AUTO_REPEAT_EN
      dir_q       <= 1'b0;
      timer_q     <= '0;
`endif
    end else begin
      sync1_q     <= {btn_down, btn_up};
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      deb_cnt_q   <= deb_cnt_d;
      startup_q   <= startup_d;
      block_q     <= block_d;
      state_q     <= state_d;
      increase_q  <= inc_d;
      decrease_q  <= dec_d;
`ifdef STEP_AUTO_REPEAT_EN
      repeating_q <= (state_d == ST_REPEAT);
      dir_q       <= dir_d;
      timer_q     <= timer_d;
`else
      repeating_q <= 1'b0;
`endif
    end
  end

  assign increase  = increase_q;
  assign decrease  = decrease_q;
  assign repeating = repeating_q;

endmodule

// File: tb/tb_step_pulse_generator.sv
module tb_step_pulse_generator;

`ifdef STEP_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, btn_up, btn_down, enable;
  logic inc_s, dec_s, rep_s;
  logic inc_l, dec_l, rep_l;
  int   checks = 0;
  int   errors = 0;
  int   pulses;

  always #5 clk = ~clk;

  step_pulse_generator #(
    .CNT_W(16), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(5)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .enable(enable),
    .increase(inc_s), .decrease(dec_s), .repeating(rep_s)
  );

  step_pulse_generator #(
    .CNT_W(16), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(1000), .REPEAT_CYCLES(200)
  ) dut_long (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .enable(enable),
    .increase(inc_l), .decrease(dec_l), .repeating(rep_l)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; btn_up = 1'b0; btn_down = 1'b0; enable = 1'b1;

    // reset state
    tick(); tick();
    chk("rst_inc", inc_s, 0); chk("rst_dec", dec_s, 0); chk("rst_rep", rep_s, 0);
    chk("rst_inc_l", inc_l, 0); chk("rst_dec_l", dec_l, 0); chk("rst_rep_l", rep_l, 0);
    rst = 1'b1;
    tick();
    chk("first_inc", inc_s, 0); chk("first_dec", dec_s, 0);
    repeat (4) tick();

    // single press, long hold time: one increase 8 edges after the raise
    btn_up = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      tick();
      chk($sformatf("t1_inc_%0d", i), inc_l, (i == 8));
      chk($sformatf("t1_dec_%0d", i), dec_l, 0);
      chk($sformatf("t1_rep_%0d", i), rep_l, 0);
      if (i == 20) btn_up = 1'b0;
    end

    // short glitches on down never debounce
    for (int g = 0; g < 5; g++) begin
      btn_down = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick(); chk($sformatf("t2_hi_%0d_%0d", g, i), dec_s, 0);
      end
      btn_down = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick(); chk($sformatf("t2_lo_%0d_%0d", g, i), dec_s, 0);
      end
    end
    for (int i = 0; i < 15; i++) begin
      tick(); chk($sformatf("t2_tail_%0d", i), dec_s, 0);
    end

    // hold up 40 cycles: pulses at 8, 18, then every 5 until release seen at 48
    btn_up = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 55; i++) begin
      tick();
      pulses += int'(inc_s);
      chk($sformatf("t3_inc_%0d", i), inc_s,
          (i == 8) || (AR && (i == 18 || i == 23 || i == 28 || i == 33 || i == 38 || i == 43)));
      chk($sformatf("t3_dec_%0d", i), dec_s, 0);
      chk($sformatf("t3_rep_%0d", i), rep_s, AR && (i >= 18) && (i <= 47));
      if (i == 40) btn_up = 1'b0;
    end
    chk("t3_count", pulses, AR ? 7 : 1);

    // simultaneous press: up wins; down stays silent until re-pressed
    btn_up = 1'b1; btn_down = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      chk($sformatf("t4_inc_%0d", i), inc_s, (i == 8));
      chk($sformatf("t4_dec_%0d", i), dec_s, 0);
      if (i == 5)  btn_up = 1'b0;
      if (i == 30) btn_down = 1'b0;
    end
    btn_down = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      chk($sformatf("t4b_dec_%0d", i), dec_s, (i == 8));
      chk($sformatf("t4b_inc_%0d", i), inc_s, 0);
      if (i == 9) btn_down = 1'b0;
    end

    // enable dropped for one cycle while down is repeating
    btn_down = 1'b1;
    for (int i = 1; i <= 55; i++) begin
      tick();
      chk($sformatf("t5_dec_%0d", i), dec_s, (i == 8) || (AR && i == 18));
      chk($sformatf("t5_inc_%0d", i), inc_s, 0);
      chk($sformatf("t5_rep_%0d", i), rep_s, AR && (i >= 18) && (i <= 19));
      if (i == 19) enable = 1'b0;
      if (i == 20) enable = 1'b1;
      if (i == 40) btn_down = 1'b0;
    end
    btn_down = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      chk($sformatf("t5b_dec_%0d", i), dec_s, (i == 8));
      if (i == 9) btn_down = 1'b0;
    end

    // asynchronous reset mid-repeat with the button still held
    btn_up = 1'b1;
    for (int i = 1; i <= 23; i++) begin
      tick();
      chk($sformatf("t6_inc_%0d", i), inc_s, (i == 8) || (AR && (i == 18 || i == 23)));
    end
    rst = 1'b0;
    #1;
    chk("t6_async_inc", inc_s, 0); chk("t6_async_dec", dec_s, 0); chk("t6_async_rep", rep_s, 0);
    tick(); tick();
    chk("t6_rst_inc", inc_s, 0);
    rst = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk($sformatf("t6_held_inc_%0d", i), inc_s, 0);
      chk($sformatf("t6_held_rep_%0d", i), rep_s, 0);
    end
    btn_up = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick(); chk($sformatf("t6_rel_inc_%0d", i), inc_s, 0);
    end
    btn_up = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      chk($sformatf("t6b_inc_%0d", i), inc_s, (i == 8));
      chk($sformatf("t6b_dec_%0d", i), dec_s, 0);
      if (i == 9) btn_up = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
